systolic_feeder: RTL and testbench

//  Transmit side of the PE array interface: sequences weight preload and activation streaming into an

---
 rtl/systolic_feeder.sv | 176 +++++++++++++++++
 tb/tb_systolic_feeder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Feeds a weight-stationary ROWS x COLS PE grid: preloads weight rows, streams skewed activation
// vectors (lane r delayed r cycles), then flushes the array with zeros before signalling done.
module systolic_feeder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_vectors,
  input  logic [COLS*DATA_W-1:0] w_data,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [ROWS*DATA_W-1:0] a_data,
  input  logic                   a_valid,
  output logic                   a_ready,
  output logic                   EN,
  output logic                   SELECTOR,
  output logic                   W_EN,
  output logic [COLS*DATA_W-1:0] in_weight_above,
  output logic [ROWS*DATA_W-1:0] active_left,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DrainCycles = ROWS + COLS - 1;
  localparam int unsigned BeatW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DrainW      = $clog2(DrainCycles + 1);

  localparam logic [BeatW-1:0]  BeatLast  = BeatW'(ROWS - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainCycles - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StCompute,
    StDrain,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [BeatW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]    vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]    num_vec_q, num_vec_d;
  logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
  logic                w_en_q;
  logic [COLS*DATA_W-1:0] w_row_q;

  logic w_fire;
  logic a_fire;

  assign w_fire = w_valid && w_ready;
  assign a_fire = a_valid && a_ready;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    vec_cnt_d   = vec_cnt_q;
    num_vec_d   = num_vec_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoadW;
          num_vec_d  = num_vectors;
          beat_cnt_d = '0;
          vec_cnt_d  = '0;
        end
      end
      StLoadW: begin
        if (w_fire) begin
          if (beat_cnt_q == BeatLast) begin
            state_d = (num_vec_q == '0) ? StDone : StCompute;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      StCompute: begin
        if (a_fire) begin
          vec_cnt_d = vec_cnt_q + 1'b1;
          if (vec_cnt_q == num_vec_q - 1'b1) begin
            state_d     = StDrain;
            drain_cnt_d = '0;
          end
        end
      end
      StDrain: begin
        if (drain_cnt_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Ready depends only on state and counters, never on valid.
  always_comb begin
    w_ready  = 1'b0;
    a_ready  = 1'b0;
    EN       = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      StIdle:    busy = 1'b0;
      StLoadW:   begin
        w_ready = 1'b1;
        EN      = 1'b1;
      end
      StCompute: begin
        a_ready = (vec_cnt_q < num_vec_q);
        EN      = 1'b1;
      end
      StDrain:   EN = 1'b1;
      StDone:    done = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  // SELECTOR stays high through the cycle that presents the final weight row.
  assign SELECTOR        = (state_q == StLoadW) || w_en_q;
  assign W_EN            = w_en_q;
  assign in_weight_above = w_row_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      vec_cnt_q   <= '0;
      num_vec_q   <= '0;
      drain_cnt_q <= '0;
      w_en_q      <= 1'b0;
      w_row_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      vec_cnt_q   <= vec_cnt_d;
      num_vec_q   <= num_vec_d;
      drain_cnt_q <= drain_cnt_d;
      w_en_q      <= w_fire;
      if (w_fire) begin
        w_row_q <= w_data;
      end
    end
  end

  // Lane r is a chain of r+1 registers; idle cycles push zeros so the array never stalls.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [DATA_W-1:0] lane_q [0:r];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k <= r; k++) begin
          lane_q[k] <= '0;
        end
      end else begin
        lane_q[0] <= a_fire ? a_data[r*DATA_W +: DATA_W] : '0;
        for (int k = 1; k <= r; k++) begin
          lane_q[k] <= lane_q[k-1];
        end
      end
    end

    assign active_left[r*DATA_W +: DATA_W] = lane_q[r];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: reset/idle table, directed job sequences and randomized jobs, all
// checked every cycle against a cycle-timeline model of accepted beats and vectors.
module tb_systolic_feeder;

  localparam int DATA_W = 16;
  localparam int ROWS   = 8;
  localparam int COLS   = 16;
  localparam int CNT_W  = 16;
  localparam int D      = ROWS + COLS - 1;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic [CNT_W-1:0]       num_vectors = '0;
  logic [COLS*DATA_W-1:0] w_data = '0;
  logic                   w_valid = 1'b0;
  logic                   w_ready;
  logic [ROWS*DATA_W-1:0] a_data = '0;
  logic                   a_valid = 1'b0;
  logic                   a_ready;
  logic                   EN;
  logic                   SELECTOR;
  logic                   W_EN;
  logic [COLS*DATA_W-1:0] in_weight_above;
  logic [ROWS*DATA_W-1:0] active_left;
  logic                   busy;
  logic                   done;

  systolic_feeder #(
    .DATA_W(DATA_W),
    .ROWS  (ROWS),
    .COLS  (COLS),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .num_vectors    (num_vectors),
    .w_data         (w_data),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .a_data         (a_data),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .EN             (EN),
    .SELECTOR       (SELECTOR),
    .W_EN           (W_EN),
    .in_weight_above(in_weight_above),
    .active_left    (active_left),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int wen_cnt = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: job timeline built from accepted handshakes (cycle-indexed).
  bit                     m_job = 1'b0;
  int                     m_start = 0;
  int                     m_wbeats = 0;
  int                     m_last_w = -100;
  int                     m_vcnt = 0;
  int                     m_nv = 0;
  int                     m_done = -1;
  logic [COLS*DATA_W-1:0] m_w = '0;
  logic [ROWS*DATA_W-1:0] m_vec [int];

  bit                     eb, ewr, ear, ewen, esel, edone, een;
  logic [ROWS*DATA_W-1:0] eact, tmp;

  always @(negedge clk) begin
    if (!reset) begin
      m_job = 1'b0;
      m_last_w = -100;
      m_done = -1;
      m_w = '0;
      m_vec.delete();
      chk("reset_ctrl", {busy, w_ready, a_ready, EN, SELECTOR, W_EN, done}, 7'd0);
      chk("reset_weights", in_weight_above, '0);
      chk("reset_acts", active_left, '0);
    end else begin
      eb    = m_job && (cyc > m_start) && (m_done < 0 || cyc <= m_done);
      ewr   = eb && (m_wbeats < ROWS);
      ear   = eb && (m_wbeats == ROWS) && (m_vcnt < m_nv);
      ewen  = (m_last_w == cyc - 1);
      esel  = ewr || ewen;
      edone = eb && (cyc == m_done);
      een   = eb && !edone;
      eact  = '0;
      for (int r = 0; r < ROWS; r++) begin
        if (m_vec.exists(cyc - 1 - r)) begin
          tmp = m_vec[cyc - 1 - r];
          eact[r*DATA_W +: DATA_W] = tmp[r*DATA_W +: DATA_W];
        end
      end
      chk("busy", busy, eb);
      chk("w_ready", w_ready, ewr);
      chk("a_ready", a_ready, ear);
      chk("EN", EN, een);
      chk("SELECTOR", SELECTOR, esel);
      chk("W_EN", W_EN, ewen);
      chk("done", done, edone);
      chk("in_weight_above", in_weight_above, m_w);
      chk("active_left", active_left, eact);
      if (start && !eb) begin
        m_job = 1'b1;
        m_start = cyc;
        m_nv = int'(num_vectors);
        m_wbeats = 0;
        m_vcnt = 0;
        m_done = -1;
      end else begin
        if (w_valid && ewr) begin
          m_w = w_data;
          m_last_w = cyc;
          m_wbeats++;
          if (m_wbeats == ROWS && m_nv == 0) m_done = cyc + 1;
        end
        if (a_valid && ear) begin
          m_vec[cyc] = a_data;
          m_vcnt++;
          if (m_vcnt == m_nv) m_done = cyc + 1 + D;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wen_cnt += int'(W_EN);
    done_cnt += int'(done);
  endtask

  // wpat/apat: 0 back-to-back, 1 gaps (every other / one bubble after vector 1), 2 random.
  task automatic run_job(input int nv, input int wpat, input int apat, input bit rnd,
                         input int abort_at);
    int beats, vecs, guard;
    bit fire, bubbled;
    wen_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    num_vectors = CNT_W'(nv);
    step();
    start = 1'b0;
    beats = 0;
    guard = 0;
    while (beats < ROWS && guard < 200) begin
      case (wpat)
        0:       w_valid = 1'b1;
        1:       w_valid = (guard % 2 == 0);
        default: w_valid = ($urandom_range(0, 2) != 0);
      endcase
      for (int c = 0; c < COLS; c++) begin
        w_data[c*DATA_W +: DATA_W] = rnd ? DATA_W'($urandom) : DATA_W'(beats + 1);
      end
      if (rnd) start = ($urandom_range(0, 5) == 0);
      fire = w_valid && w_ready;
      step();
      if (fire) beats++;
      guard++;
    end
    w_valid = 1'b0;
    start = 1'b0;
    chk("weight_beats_taken", beats, ROWS);
    vecs = 0;
    bubbled = 1'b0;
    while (vecs < nv && guard < 400) begin
      if (abort_at >= 0 && vecs == abort_at) break;
      case (apat)
        0: a_valid = 1'b1;
        1: begin
          a_valid = !(vecs == 1 && !bubbled);
          if (vecs == 1) bubbled = 1'b1;
        end
        default: a_valid = ($urandom_range(0, 2) != 0);
      endcase
      for (int r = 0; r < ROWS; r++) begin
        a_data[r*DATA_W +: DATA_W] = rnd ? DATA_W'($urandom) : DATA_W'(6);
      end
      if (rnd) start = ($urandom_range(0, 5) == 0);
      fire = a_valid && a_ready;
      step();
      if (fire) vecs++;
      guard++;
    end
    a_valid = 1'b0;
    start = 1'b0;
    if (abort_at >= 0) begin
      reset = 1'b0;
      step();
      chk("abort_en", EN, 1'b0);
      chk("abort_busy", busy, 1'b0);
      step();
      reset = 1'b1;
      done_cnt = 0;
      repeat (D + 8) step();
      chk("abort_no_done", done_cnt, 0);
      chk("abort_idle", busy, 1'b0);
    end else begin
      chk("vectors_taken", vecs, nv);
      repeat (D + 8) step();
      chk("done_pulses", done_cnt, 1);
      chk("weight_enables", wen_cnt, ROWS);
      chk("busy_after_job", busy, 1'b0);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          st;
    bit          wv;
    bit          av;
    logic [15:0] pat;
    logic [6:0]  exp;  // {busy, w_ready, a_ready, EN, SELECTOR, W_EN, done}
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 7'b0000000};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hA5A5, 7'b0000000};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h5A5A, 7'b0000000};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 7'b0000000};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h00FF, 7'b0000000};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hFF00, 7'b0000000};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 7'b1101100};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF, 7'b0000000};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b0000000};
    for (int i = 0; i < 9; i++) begin
      reset = tbl[i].rst;
      start = tbl[i].st;
      w_valid = tbl[i].wv;
      a_valid = tbl[i].av;
      num_vectors = tbl[i].pat;
      w_data = {COLS{tbl[i].pat}};
      a_data = {ROWS{tbl[i].pat}};
      step();
      chk($sformatf("table_ctrl_%0d", i),
          {busy, w_ready, a_ready, EN, SELECTOR, W_EN, done}, tbl[i].exp);
      chk($sformatf("table_buses_%0d", i), {in_weight_above, active_left}, '0);
    end
    start = 1'b0;
    w_valid = 1'b0;
    a_valid = 1'b0;
    repeat (2) step();

    run_job(1, 0, 0, 1'b0, -1);
    run_job(1, 1, 0, 1'b0, -1);
    run_job(3, 0, 1, 1'b0, -1);
    run_job(0, 0, 0, 1'b0, -1);
    run_job(5, 0, 0, 1'b1, 2);
    for (int j = 0; j < 25; j++) begin
      run_job($urandom_range(0, 6), 2, 2, 1'b1, -1);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
